// File: rtl/instruction_feeder_if.sv
// instruction_feeder_if: host/processor-side signal bundle for the instruction feeder.
interface instruction_feeder_if #(parameter int DEPTH = 16);
    localparam int AW = $clog2(DEPTH);
    logic          Load;
    logic [AW-1:0] LoadAddr;
    logic [8:0]    LoadData;
    logic [AW:0]   Length;
    logic          Start;
    logic          Done;
    logic [8:0]    DIN;
    logic          Run;
    logic          Busy;
    logic          Finished;
    logic          Error;
    logic [AW:0]   InstrCount;
    modport master (
        output Load, LoadAddr, LoadData, Length, Start, Done,
        input  DIN, Run, Busy, Finished, Error, InstrCount
    );
    modport slave (
        input  Load, LoadAddr, LoadData, Length, Start, Done,
        output DIN, Run, Busy, Finished, Error, InstrCount
    );
endinterface

// File: rtl/instruction_feeder.sv
// instruction_feeder: replays a loaded 9-bit program to a processor, one instruction per Done,
// with a per-instruction Done timeout and a missing-immediate check.
module instruction_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input logic Clock,
    input logic Reset,
    instruction_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_IMM    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic [2:0]    r_state, w_next;
    logic [AW:0]   r_pc, w_pc, r_len, w_len, r_cnt, w_cnt;
    logic [TW-1:0] r_tmo, w_tmo;
    logic [8:0]    r_mem [DEPTH];
    logic [AW:0]   w_len_eff, w_pc_inc;
    logic [8:0]    w_word, w_word_inc;
    logic          w_busy;

    // An mvi as the last word has no immediate to follow it, so it is refused before issue.
    function automatic logic [2:0] decide(input logic [AW:0] p, input logic [AW:0] l, input logic [8:0] wd);
        return (p == l) ? S_FINISH : (wd[8:6] == 3'b001 && p + 1'b1 == l) ? S_ERROR : S_ISSUE;
    endfunction

    assign w_len_eff  = (bus.Length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.Length;
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_word     = r_mem[r_pc[AW-1:0]];
    assign w_word_inc = r_mem[w_pc_inc[AW-1:0]];
    assign w_busy     = r_state == S_ISSUE || r_state == S_IMM || r_state == S_WAIT;

    always_comb begin
        w_next = r_state;
        w_pc   = r_pc;
        w_len  = r_len;
        w_cnt  = r_cnt;
        w_tmo  = r_tmo;
        case (r_state)
            S_IDLE, S_ERROR: if (bus.Start) begin
                w_len  = w_len_eff;
                w_pc   = '0;
                w_cnt  = '0;
                w_next = decide('0, w_len_eff, r_mem[0]);
            end
            S_ISSUE: begin
                w_pc   = w_pc_inc;
                w_tmo  = '0;
                w_next = (w_word[8:6] == 3'b001) ? S_IMM : S_WAIT;
            end
            S_IMM: begin
                w_pc   = w_pc_inc;
                w_cnt  = bus.Done ? r_cnt + 1'b1 : r_cnt;
                w_next = bus.Done ? decide(w_pc_inc, r_len, w_word_inc) : S_WAIT;
            end
            S_WAIT: if (bus.Done) begin
                w_cnt  = r_cnt + 1'b1;
                w_next = decide(r_pc, r_len, w_word);
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                w_next = S_ERROR;
            end else begin
                w_tmo = r_tmo + 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc;
            r_len   <= w_len;
            r_cnt   <= w_cnt;
            r_tmo   <= w_tmo;
        end
    end

    // Program buffer survives reset on purpose so a re-Start replays it.
    always_ff @(posedge Clock) begin
        if (bus.Load && !w_busy)
            r_mem[bus.LoadAddr] <= bus.LoadData;
    end

    assign bus.DIN        = (r_state == S_ISSUE || r_state == S_IMM) ? w_word : '0;
    assign bus.Run        = r_state == S_ISSUE;
    assign bus.Busy       = w_busy;
    assign bus.Finished   = r_state == S_FINISH;
    assign bus.Error      = r_state == S_ERROR;
    assign bus.InstrCount = r_cnt;
endmodule

// File: tb/tb_instruction_feeder.sv
// tb_instruction_feeder: directed programs with a scoreboard of expected Run/Finished/Error events.
module tb_instruction_feeder;
    typedef struct packed {
        logic [1:0] k;
        logic [8:0] d;
    } ev_t;
    localparam logic [1:0] E_RUN = 2'd0;
    localparam logic [1:0] E_FIN = 2'd1;
    localparam logic [1:0] E_ERR = 2'd2;

    logic Clock;
    logic Reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    ev_t  exp_q[$];
    logic err_prev = 1'b0;

    instruction_feeder_if #(.DEPTH(16)) bus();
    instruction_feeder #(.DEPTH(16), .TIMEOUT(64)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [8:0] d);
        exp_q.push_back('{k: k, d: d});
    endtask

    task automatic got(input logic [1:0] k, input logic [8:0] d);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.k !== k || e.d !== d) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h", k, d, e.k, e.d);
            end
        end
    endtask

    always @(negedge Clock) begin
        if (!Reset) begin
            if (bus.Run) got(E_RUN, bus.DIN);
            if (bus.Finished) got(E_FIN, {4'b0, bus.InstrCount});
            if (bus.Error && !err_prev) got(E_ERR, {4'b0, bus.InstrCount});
        end
        err_prev = bus.Error;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [8:0] d);
        bus.Load = 1'b1;
        bus.LoadAddr = a;
        bus.LoadData = d;
        step(1);
        bus.Load = 1'b0;
    endtask

    task automatic start_prog(input logic [4:0] len);
        bus.Length = len;
        bus.Start = 1'b1;
        step(1);
        bus.Start = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_din"}, bus.DIN, 0);
        check({name, "_run"}, bus.Run, 0);
        check({name, "_busy"}, bus.Busy, 0);
        check({name, "_fin"}, bus.Finished, 0);
        check({name, "_err"}, bus.Error, 0);
        check({name, "_cnt"}, bus.InstrCount, 0);
    endtask

    initial begin
        Reset = 1'b1;
        bus.Load = 1'b0;
        bus.LoadAddr = '0;
        bus.LoadData = '0;
        bus.Length = '0;
        bus.Start = 1'b0;
        bus.Done = 1'b0;
        step(2);
        check_all_zero("reset");
        Reset = 1'b0;
        step(1);

        // mvi R0,5 ; add R0,R0
        load(4'd0, 9'h040);
        load(4'd1, 9'h005);
        load(4'd2, 9'h080);
        expect_ev(E_RUN, 9'h040);
        expect_ev(E_RUN, 9'h080);
        expect_ev(E_FIN, 9'd2);
        start_prog(5'd3);
        step(1);
        check("imm_din", bus.DIN, 9'h005);
        check("imm_run", bus.Run, 0);
        check("imm_busy", bus.Busy, 1);
        bus.Done = 1'b1;
        step(1);
        bus.Done = 1'b0;
        step(1);
        bus.Done = 1'b1;
        step(1);
        bus.Done = 1'b0;
        check("t1_cnt", bus.InstrCount, 2);
        step(1);
        check("t1_idle_busy", bus.Busy, 0);

        // empty program
        expect_ev(E_FIN, 9'd0);
        start_prog(5'd0);
        check("len0_fin", bus.Finished, 1);
        check("len0_cnt", bus.InstrCount, 0);
        step(2);

        // timeout on a single mv
        load(4'd0, 9'h001);
        expect_ev(E_RUN, 9'h001);
        expect_ev(E_ERR, 9'd0);
        start_prog(5'd1);
        step(64);
        check("tmo_63_busy", bus.Busy, 1);
        check("tmo_63_err", bus.Error, 0);
        step(1);
        check("tmo_err", bus.Error, 1);
        check("tmo_busy", bus.Busy, 0);
        step(3);
        check("err_sticky", bus.Error, 1);
        expect_ev(E_RUN, 9'h001);
        expect_ev(E_FIN, 9'd1);
        start_prog(5'd1);
        check("err_clear", bus.Error, 0);
        step(1);
        bus.Done = 1'b1;
        step(1);
        bus.Done = 1'b0;
        step(1);

        // trailing mvi without immediate
        load(4'd0, 9'h040);
        expect_ev(E_ERR, 9'd0);
        start_prog(5'd1);
        check("noimm_err", bus.Error, 1);
        check("noimm_run", bus.Run, 0);
        check("noimm_cnt", bus.InstrCount, 0);
        step(2);

        // reset in WAIT of instruction 2, then rerun
        load(4'd0, 9'h080);
        load(4'd1, 9'h0C1);
        load(4'd2, 9'h002);
        load(4'd3, 9'h088);
        expect_ev(E_RUN, 9'h080);
        expect_ev(E_RUN, 9'h0C1);
        start_prog(5'd4);
        step(1);
        bus.Done = 1'b1;
        step(1);
        bus.Done = 1'b0;
        step(1);
        check("pre_rst_busy", bus.Busy, 1);
        Reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        step(2);
        Reset = 1'b0;
        step(1);
        expect_ev(E_RUN, 9'h080);
        expect_ev(E_RUN, 9'h0C1);
        expect_ev(E_RUN, 9'h002);
        expect_ev(E_RUN, 9'h088);
        expect_ev(E_FIN, 9'd4);
        start_prog(5'd4);
        for (int i = 0; i < 4; i++) begin
            step(1);
            bus.Done = 1'b1;
            step(1);
            bus.Done = 1'b0;
        end
        step(1);
        check("rerun_cnt", bus.InstrCount, 4);

        // Load/Start while busy, Done in IDLE
        expect_ev(E_RUN, 9'h080);
        expect_ev(E_RUN, 9'h0C1);
        expect_ev(E_FIN, 9'd2);
        start_prog(5'd2);
        bus.Load = 1'b1;
        bus.LoadAddr = 4'd1;
        bus.LoadData = 9'h1FF;
        bus.Length = 5'd0;
        bus.Start = 1'b1;
        step(1);
        bus.Load = 1'b0;
        bus.Start = 1'b0;
        check("busy_start_ign", bus.Busy, 1);
        bus.Done = 1'b1;
        step(1);
        bus.Done = 1'b0;
        step(1);
        bus.Done = 1'b1;
        step(1);
        bus.Done = 1'b0;
        step(1);
        bus.Done = 1'b1;
        step(2);
        bus.Done = 1'b0;
        check("idle_done_busy", bus.Busy, 0);
        check("idle_done_run", bus.Run, 0);
        check("idle_done_cnt", bus.InstrCount, 2);

        // Length beyond DEPTH clamps to a full 16-word run
        for (int i = 0; i < 16; i++) load(4'(i), 9'(i + 1));
        for (int i = 0; i < 16; i++) expect_ev(E_RUN, 9'(i + 1));
        expect_ev(E_FIN, 9'd16);
        start_prog(5'd31);
        for (int i = 0; i < 16; i++) begin
            step(1);
            bus.Done = 1'b1;
            step(1);
            bus.Done = 1'b0;
        end
        check("full_cnt", bus.InstrCount, 16);
        step(2);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_feeder.md
INSTRUCTION_FEEDER -- requirements
Module: instruction_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 9-bit program words held.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for Done per instruction.
REQ-003 SHALL provide Clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL provide Load  in  1  write strobe for the program buffer.
REQ-006 SHALL provide LoadAddr  in  4  program buffer write address.
REQ-007 SHALL provide LoadData  in  9  program word; the format is III XXX YYY, where III is the opcode: 000 mv, 001 mvi, 010 add, 011 sub.
REQ-008 SHALL provide Length  in  5  number of valid words (0..16), sampled on Start.
REQ-009 SHALL provide Start  in  1  single-cycle request to execute the program from address 0.
REQ-010 SHALL provide Done  in  1  instruction-complete flag from the processor.
REQ-011 SHALL provide DIN  out  9  instruction or immediate word driven to the processor.
REQ-012 SHALL provide Run  out  1  instruction-valid strobe to the processor.
REQ-013 SHALL provide Busy  out  1  high while a program is executing.
REQ-014 SHALL provide Finished  out  1  one-cycle pulse when the program completes normally.
REQ-015 SHALL provide Error  out  1  sticky fault flag.
REQ-016 SHALL provide InstrCount  out  5  number of instructions completed in the current or last run.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, IMM, WAIT, FINISH, ERROR; all outputs are Moore, decoded from registered state.
REQ-018 SHALL write LoadData to mem[LoadAddr] on a Load edge only when Busy=0; Load while Busy=1 is ignored.
REQ-019 SHALL, on Start in IDLE or ERROR: latch Length, clear PC, InstrCount and Error, and take the next-instruction decision (REQ-024).
REQ-020 SHALL ignore Start while Busy=1.
REQ-021 SHALL in ISSUE drive Run=1 and DIN=mem[PC] for exactly one cycle, then increment PC.
REQ-022 SHALL go from ISSUE to IMM if the opcode is 001 (mvi), else to WAIT.
REQ-023 SHALL in IMM drive Run=0 and DIN=mem[PC] (the immediate) for one cycle, increment PC, then go to WAIT.
REQ-024 SHALL take the next-instruction decision as follows:
- PC==Length -> FINISH.
- mem[PC] is mvi and PC+1==Length -> ERROR, with no Run (missing immediate).
- otherwise -> ISSUE.
REQ-025 SHALL sample Done only in IMM and WAIT; Done=1 increments InstrCount and takes the next-instruction decision on the same edge.
REQ-026 SHALL ignore Done in IDLE, ISSUE, FINISH and ERROR.
REQ-027 SHALL drive DIN=0 and Run=0 in all states other than ISSUE and IMM.
REQ-028 SHALL count cycles spent in WAIT with Done=0; on reaching TIMEOUT it goes to ERROR, and the counter clears on each new ISSUE.
REQ-029 SHALL assert Busy in ISSUE, IMM and WAIT only.
REQ-030 SHALL assert Finished in FINISH (one cycle), then go to IDLE.
REQ-031 SHALL assert Error in ERROR and hold it until Start or Reset; Busy=0 in ERROR.
REQ-032 SHALL, on Start with Length=0, go IDLE -> FINISH directly: Finished pulses one cycle after Start, Run never asserts, InstrCount=0.
REQ-033 SHALL treat Length>DEPTH as DEPTH.
REQ-034 SHALL use 5-bit PC and 5-bit InstrCount, so that InstrCount=16 is representable without wrap.

Reset
REQ-035 SHALL, on Reset=1, immediately force state IDLE, PC=0, InstrCount=0, timeout counter=0, DIN=0, Run=0, Busy=0, Finished=0, Error=0.
REQ-036 SHALL abort a program mid-run on reset without any further Run pulse; program buffer contents are not reset and are retained.

Verification
REQ-037 SHALL cover: load {mvi R0 (001000000), 0x005, add R0,R0 (010000000)}, Length=3, Start, Done returned in IMM and one cycle after the add ISSUE -> Run pulses twice, DIN sequence 0x040, 0x005, 0x080, InstrCount=2, Finished pulse.
REQ-038 SHALL cover: Length=0, Start -> Finished high one cycle later, Run never high, InstrCount=0.
REQ-039 SHALL cover: single mv word, Done held low for 64 cycles -> Error=1, Busy=0; then Start with Done returned -> Error clears, Finished pulses.
REQ-040 SHALL cover: Length=1 with word 001000000 (mvi) -> ERROR with no Run pulse, InstrCount=0.
REQ-041 SHALL cover: Reset asserted in WAIT of the 2nd of 4 instructions -> all outputs 0 asynchronously; a re-Start reruns the same program from address 0.
REQ-042 SHALL cover: Load and Start asserted while Busy -> buffer unchanged and run unaffected; Done pulses in IDLE -> no state change.
